// File: rtl/rot_enc_decoder.sv
// Rotary-encoder input conditioning: 2-flop sync + debounce on A/B/PB, full-detent
// quadrature decode into step pulses, wrapping position count, short/long press events.
module rot_enc_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES   = 20,
    parameter int unsigned LONG_PRESS_CYCLES = 10000,
    parameter int unsigned POS_WIDTH         = 8,
    parameter logic        PB_ACTIVE_LOW     = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_pb,
    input  logic                 pos_clr,
    output logic                 step_cw,
    output logic                 step_ccw,
    output logic [POS_WIDTH-1:0] position,
    output logic                 pb_level,
    output logic                 pb_press,
    output logic                 pb_long
);

    localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] LONG_MAX  = 16'(LONG_PRESS_CYCLES);
    localparam logic [15:0] LONG_LAST = 16'(LONG_PRESS_CYCLES - 1);
    // Bit order everywhere: [2]=A, [1]=B, [0]=PB. Sync flops hold raw pin levels.
    localparam logic [2:0]  SYNC_RST  = {2'b11, PB_ACTIVE_LOW};
    localparam logic [2:0]  DEB_RST   = 3'b110;
    localparam logic [POS_WIDTH-1:0] POS_ONE = {{(POS_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] synced;
    logic [2:0] deb;
    logic [7:0] db_cnt [3];

    logic [1:0] ab;
    logic [1:0] ab_prev;
    logic [3:0] acc;
    logic [1:0] delta;
    logic [4:0] acc_sum;
    logic [3:0] acc_next;
    logic       into_rest;
    logic       cw_d;
    logic       ccw_d;

    logic        pb_prev;
    logic [15:0] hold_cnt;

    assign synced = {sync2[2:1], sync2[0] ^ PB_ACTIVE_LOW};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
        end else begin
            sync1 <= {enc_a, enc_b, enc_pb};
            sync2 <= sync1;
        end
    end

    // Counter runs only while synced disagrees with debounced; any agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= DEB_RST;
            for (int i = 0; i < 3; i++) db_cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (synced[i] == deb[i]) begin
                    db_cnt[i] <= 8'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= synced[i];
                    db_cnt[i] <= 8'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign ab = deb[2:1];

    // delta is a 2-bit signed step: 01 = +1 (CW), 11 = -1 (CCW), 00 = none/illegal.
    always_comb begin
        delta = 2'b00;
        case ({ab_prev, ab})
            4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: delta = 2'b01;
            4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: delta = 2'b11;
            default:                                 delta = 2'b00;
        endcase
    end

    always_comb begin
        acc_sum  = {acc[3], acc} + {{3{delta[1]}}, delta};
        acc_next = acc_sum[3:0];
        if ($signed(acc_sum) > 5'sd7) begin
            acc_next = 4'b0111;
        end else if ($signed(acc_sum) < -5'sd7) begin
            acc_next = 4'b1001;
        end
        into_rest = (ab == 2'b11) && (ab_prev != 2'b11);
        cw_d      = into_rest && (acc_next == 4'b0100);
        ccw_d     = into_rest && (acc_next == 4'b1100);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_prev  <= 2'b11;
            acc      <= 4'd0;
            step_cw  <= 1'b0;
            step_ccw <= 1'b0;
            position <= '0;
        end else begin
            ab_prev  <= ab;
            acc      <= into_rest ? 4'd0 : acc_next;
            step_cw  <= cw_d;
            step_ccw <= ccw_d;
            // Position moves on the same edge the step pulse rises; clear wins.
            if (pos_clr) begin
                position <= '0;
            end else if (cw_d) begin
                position <= position + POS_ONE;
            end else if (ccw_d) begin
                position <= position - POS_ONE;
            end
        end
    end

    assign pb_level = deb[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_prev  <= 1'b0;
            pb_press <= 1'b0;
            pb_long  <= 1'b0;
            hold_cnt <= 16'd0;
        end else begin
            pb_prev  <= deb[0];
            pb_press <= deb[0] && !pb_prev;
            pb_long  <= deb[0] && (hold_cnt == LONG_LAST);
            if (!deb[0]) begin
                hold_cnt <= 16'd0;
            end else if (hold_cnt != LONG_MAX) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rot_enc_decoder.sv
// Bench for rot_enc_decoder: expected pulse events queued as stimulus is driven,
// popped and compared by a negedge monitor, plus direct level/latency checks.
module tb_rot_enc_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enc_a = 1'b1;
    logic       enc_b = 1'b1;
    logic       enc_pb = 1'b0;
    logic       pos_clr = 1'b0;
    logic       step_cw;
    logic       step_ccw;
    logic [7:0] position;
    logic       pb_level;
    logic       pb_press;
    logic       pb_long;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lvl_rise_cyc = -1;
    int long_cyc     = -1;
    logic pb_level_q = 1'b0;
    logic [15:0] exp_q[$];

    rot_enc_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .enc_pb   (enc_pb),
        .pos_clr  (pos_clr),
        .step_cw  (step_cw),
        .step_ccw (step_ccw),
        .position (position),
        .pb_level (pb_level),
        .pb_press (pb_press),
        .pb_long  (pb_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Event word: kind in [15:12] (1=cw, 2=ccw, 3=press, 4=long), position in [7:0].
    function automatic logic [15:0] ev(input logic [3:0] kind, input logic [7:0] pos);
        return {kind, 4'h0, pos};
    endfunction

    task automatic sb_pop(input logic [15:0] obs);
        if (exp_q.size() == 0) check_eq("unexpected_event", {16'h0, obs}, 32'd0);
        else                   check_eq("event", {16'h0, obs}, {16'h0, exp_q.pop_front()});
    endtask

    always @(negedge clk) begin
        if (step_cw || step_ccw) check_eq("step_excl", {31'd0, step_cw & step_ccw}, 32'd0);
        if (step_cw)  sb_pop(ev(4'd1, position));
        if (step_ccw) sb_pop(ev(4'd2, position));
        if (pb_press) sb_pop(ev(4'd3, 8'd0));
        if (pb_long) begin
            sb_pop(ev(4'd4, 8'd0));
            long_cyc <= cyc;
        end
        if (pb_level && !pb_level_q) lvl_rise_cyc <= cyc;
        pb_level_q <= pb_level;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_ab(input logic [1:0] ab, input int n);
        {enc_a, enc_b} = ab;
        wait_clk(n);
    endtask

    task automatic cw_cycle();
        drive_ab(2'b01, 30); drive_ab(2'b00, 30); drive_ab(2'b10, 30); drive_ab(2'b11, 30);
    endtask

    task automatic ccw_cycle();
        drive_ab(2'b10, 30); drive_ab(2'b00, 30); drive_ab(2'b01, 30); drive_ab(2'b11, 30);
    endtask

    // Clocks from a pin change until pb_level reaches target (bounded at 100).
    task automatic measure_level(input logic target, output int n);
        n = 0;
        while (pb_level !== target && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset with pins at rest
        wait_clk(3);
        #1;
        check_eq("rst_position", {24'd0, position}, 32'd0);
        check_eq("rst_steps", {30'd0, step_cw, step_ccw}, 32'd0);
        check_eq("rst_pb", {29'd0, pb_level, pb_press, pb_long}, 32'd0);
        wait_clk(1);
        rst_n = 1'b1;
        wait_clk(5);
        check_eq("idle_position", {24'd0, position}, 32'd0);

        // One clean CW detent
        exp_q.push_back(ev(4'd1, 8'd1));
        cw_cycle();
        wait_clk(10);
        check_eq("cw_position", {24'd0, position}, 32'd1);
        check_eq("cw_q_empty", exp_q.size(), 32'd0);

        // Clear, then three CCW detents wrapping below zero
        pos_clr = 1'b1;
        wait_clk(1);
        pos_clr = 1'b0;
        wait_clk(1);
        check_eq("clr_position", {24'd0, position}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(ev(4'd2, 8'(256 - i)));
            ccw_cycle();
        end
        wait_clk(5);
        check_eq("ccw_position", {24'd0, position}, 32'd253);
        check_eq("ccw_q_empty", exp_q.size(), 32'd0);

        // Fourth CCW detent with pos_clr held across the step
        exp_q.push_back(ev(4'd2, 8'd0));
        drive_ab(2'b10, 30); drive_ab(2'b00, 30); drive_ab(2'b01, 30);
        pos_clr = 1'b1;
        drive_ab(2'b11, 30);
        pos_clr = 1'b0;
        wait_clk(5);
        check_eq("clr_step_position", {24'd0, position}, 32'd0);
        check_eq("clr_step_q_empty", exp_q.size(), 32'd0);

        // Half turn and short glitches on A: nothing expected
        drive_ab(2'b01, 30); drive_ab(2'b00, 30); drive_ab(2'b01, 30); drive_ab(2'b11, 30);
        repeat (3) begin
            enc_a = 1'b0; wait_clk(5);
            enc_a = 1'b1; wait_clk(30);
        end
        check_eq("half_position", {24'd0, position}, 32'd0);
        check_eq("half_q_empty", exp_q.size(), 32'd0);

        // Bouncy short press
        long_cyc = -1;
        exp_q.push_back(ev(4'd3, 8'd0));
        for (int i = 0; i < 10; i++) begin
            enc_pb = (i % 2 == 0);
            wait_clk(1);
        end
        enc_pb = 1'b1;
        measure_level(1'b1, n);
        check_eq("press_latency", n, 32'd22);
        wait_clk(100 - 22);
        enc_pb = 1'b0;
        wait_clk(40);
        check_eq("short_level", {31'd0, pb_level}, 32'd0);
        check_eq("short_no_long", long_cyc, 32'hFFFF_FFFF);
        check_eq("short_q_empty", exp_q.size(), 32'd0);

        // Long press
        exp_q.push_back(ev(4'd3, 8'd0));
        exp_q.push_back(ev(4'd4, 8'd0));
        enc_pb = 1'b1;
        measure_level(1'b1, n);
        check_eq("long_press_latency", n, 32'd22);
        wait_clk(12000 - 22);
        enc_pb = 1'b0;
        measure_level(1'b0, n);
        check_eq("release_latency", n, 32'd22);
        check_eq("long_delay", long_cyc - lvl_rise_cyc, 32'd10000);
        wait_clk(10);
        check_eq("long_q_empty", exp_q.size(), 32'd0);

        // Reset in the middle of a rotation, released with pins at 00
        exp_q.push_back(ev(4'd1, 8'd1));
        cw_cycle();
        wait_clk(5);
        check_eq("pre_rst_position", {24'd0, position}, 32'd1);
        drive_ab(2'b01, 30);
        drive_ab(2'b00, 30);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_position", {24'd0, position}, 32'd0);
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(40);
        drive_ab(2'b11, 40);
        check_eq("post_rst_position", {24'd0, position}, 32'd0);
        check_eq("post_rst_q_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
